// File: rtl/cla16_sum_accumulator_pkg.sv
// ----------------------------------------------------------------------------
// cla16_sum_accumulator_pkg
//   Shared widths and the result-entry record queued by cla16_sum_accumulator.
//   OPW    : operand width of the carry-look-ahead adder
//   RES_W  : result width, {carry, sum[OPW-1:0]}
//   res_entry_t : one FIFO entry, 17-bit result plus the in_last tag
// ----------------------------------------------------------------------------
package cla16_sum_accumulator_pkg;

    localparam int unsigned OPW   = 16;
    localparam int unsigned RES_W = OPW + 1;

    typedef struct packed {
        logic [RES_W-1:0] sum;
        logic             last;
    } res_entry_t;

endpackage : cla16_sum_accumulator_pkg

// File: rtl/cla16_sum_accumulator_cla.sv
// ----------------------------------------------------------------------------
// carry_look_ahead_16_4bit
//   Combinational 16-bit adder built from four 4-bit look-ahead groups with a
//   second look-ahead level across the groups.
//   a, b : operands
//   cin  : carry into bit 0
//   sum  : a + b + cin, low 16 bits
//   cout : carry out of bit 15
// ----------------------------------------------------------------------------
module carry_look_ahead_16_4bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:0]  grp_c;
    logic [15:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Group generate / propagate for each nibble
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end
    end

    // Second-level look-ahead: every group carry comes straight from cin
    always_comb begin
        grp_c    = '0;
        grp_c[0] = cin;
        grp_c[1] = grp_g[0] | (grp_p[0] & cin);
        grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
        grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
        grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);
    end

    // In-group bit carries from the group carry-in
    always_comb begin
        c = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            c[4*k]   = grp_c[k];
            c[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & grp_c[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
        end
    end

    assign sum  = p ^ c;
    assign cout = grp_c[4];

endmodule : carry_look_ahead_16_4bit

// File: rtl/cla16_sum_accumulator.sv
// ----------------------------------------------------------------------------
// cla16_sum_accumulator
//   Takes operand beats over valid/ready, adds (a or acc) + b + cin through one
//   carry-look-ahead adder, keeps a running accumulator and a saturating count
//   of carry-out beats, and queues {carry,sum,last} results in a small FIFO.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready depends on state only)
//   a, b, cin             : operands and carry-in
//   op_acc                : 1 selects the accumulator as the A operand
//   in_last               : tag forwarded to out_last
//   clr                   : synchronous clear of acc and carry_cnt
//   out_valid / out_ready : result handshake
//   out_sum, out_last     : FIFO head result and tag
//   acc, carry_cnt        : accumulator and saturating carry-out counter
// ----------------------------------------------------------------------------
module cla16_sum_accumulator
    import cla16_sum_accumulator_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    input  logic             cin,
    input  logic             op_acc,
    input  logic             in_last,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_sum,
    output logic             out_last,
    output logic [OPW-1:0]   acc,
    output logic [CNT_W-1:0] carry_cnt
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W  = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q,  count_d;
    res_entry_t       mem_q [DEPTH];
    res_entry_t       last_q,   last_d;
    logic [OPW-1:0]   acc_q,    acc_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    logic             accept;
    logic             pop;
    logic [OPW-1:0]   op_a;
    logic [OPW-1:0]   sum16;
    logic             cout;
    logic [RES_W-1:0] sum17;
    res_entry_t       new_entry;
    res_entry_t       head;

    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // A same-cycle clr zeroes the accumulator before it feeds the adder
    assign op_a = op_acc ? (clr ? '0 : acc_q) : a;

    carry_look_ahead_16_4bit u_cla (
        .a    (op_a),
        .b    (b),
        .cin  (cin),
        .sum  (sum16),
        .cout (cout)
    );

    assign sum17          = {cout, sum16};
    assign new_entry.sum  = sum17;
    assign new_entry.last = in_last;

    // With the FIFO empty the outputs keep showing the last popped entry
    assign head      = out_valid ? mem_q[rd_ptr_q] : last_q;
    assign out_sum   = head.sum;
    assign out_last  = head.last;
    assign acc       = acc_q;
    assign carry_cnt = cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            last_d   = mem_q[rd_ptr_q];
        end
        if (accept && !pop) begin
            count_d = count_q + OCC_W'(1);
        end else if (pop && !accept) begin
            count_d = count_q - OCC_W'(1);
        end
    end

    // clr takes effect first, then an accepted beat updates on top of it
    always_comb begin
        logic [CNT_W-1:0] base_cnt;
        base_cnt = clr ? '0 : cnt_q;
        acc_d    = clr ? '0 : acc_q;
        cnt_d    = base_cnt;
        if (accept) begin
            acc_d = sum17[OPW-1:0];
            if (sum17[RES_W-1] && (base_cnt != '1)) begin
                cnt_d = base_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            if (accept) begin
                mem_q[wr_ptr_q] <= new_entry;
            end
        end
    end

endmodule : cla16_sum_accumulator

// File: tb/tb_cla16_sum_accumulator.sv
// ----------------------------------------------------------------------------
// tb_cla16_sum_accumulator
//   Scoreboard bench: expected {sum17,last} entries are queued as beats are
//   accepted and compared against the FIFO head while out_valid is high.
// ----------------------------------------------------------------------------
module tb_cla16_sum_accumulator;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      a;
    logic [15:0]      b;
    logic             cin;
    logic             op_acc;
    logic             in_last;
    logic             clr;
    logic             out_valid;
    logic             out_ready;
    logic [16:0]      out_sum;
    logic             out_last;
    logic [15:0]      acc;
    logic [CNT_W-1:0] carry_cnt;

    cla16_sum_accumulator #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op_acc    (op_acc),
        .in_last   (in_last),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .acc       (acc),
        .carry_cnt (carry_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [17:0]      sbq[$];
    logic [15:0]      m_acc;
    logic [CNT_W-1:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check state just before the edge, update model, step past it
    task automatic tick(output bit accepted);
        logic [16:0]      s;
        logic [15:0]      opa;
        logic [CNT_W-1:0] base;
        bit               acc_b;
        bit               pop_b;
        @(negedge clk);
        check("acc", 32'(acc), 32'(m_acc));
        check("carry_cnt", 32'(carry_cnt), 32'(m_cnt));
        check("in_ready", 32'(in_ready), 32'(sbq.size() < DEPTH));
        check("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
        if (out_valid && sbq.size() != 0) begin
            check("head", 32'({out_sum, out_last}), 32'(sbq[0]));
        end
        acc_b = in_valid && in_ready;
        pop_b = out_valid && out_ready;
        if (pop_b && sbq.size() != 0) void'(sbq.pop_front());
        if (acc_b) begin
            opa  = op_acc ? (clr ? 16'h0 : m_acc) : a;
            s    = {1'b0, opa} + {1'b0, b} + {16'h0, cin};
            sbq.push_back({s, in_last});
            base = clr ? '0 : m_cnt;
            m_acc = s[15:0];
            m_cnt = (s[16] && base != {CNT_W{1'b1}}) ? base + 1'b1 : base;
        end else if (clr) begin
            m_acc = '0;
            m_cnt = '0;
        end
        accepted = acc_b;
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic v, input logic [15:0] ta, input logic [15:0] tb_,
                            input logic tc, input logic top, input logic tl, input logic tclr);
        in_valid = v; a = ta; b = tb_; cin = tc; op_acc = top; in_last = tl; clr = tclr;
    endtask

    // Offer one beat until accepted, bounded
    task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        input logic top, input logic tl, input logic tclr);
        bit ok = 0;
        set_beat(1'b1, ta, tb_, tc, top, tl, tclr);
        for (int i = 0; i < 50 && !ok; i++) tick(ok);
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        set_beat(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        bit dummy;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sbq.size() != 0; i++) tick(dummy);
        if (sbq.size() != 0) check("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit pending;
        int unsigned beats;

        // Reset state
        set_beat(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        rst_n     = 1'b0;
        m_acc = '0; m_cnt = '0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_cnt", 32'(carry_cnt), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Pass mode
        send(16'h1234, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0);
        check("pass_out_sum", 32'(out_sum), 32'h01236);
        check("pass_acc", 32'(acc), 32'h1236);
        check("pass_cnt", 32'(carry_cnt), 32'd0);
        drain();

        // Accumulate with carry
        send(16'hFFF0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        send(16'h0000, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b0);
        check("accum_out_sum", 32'(out_sum), 32'h10010);
        check("accum_acc", 32'(acc), 32'h0010);
        check("accum_cnt", 32'(carry_cnt), 32'd1);
        drain();
        for (int i = 0; i < 300; i++) send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'(i & 1), 1'b0);
        drain();
        check("cnt_saturated", 32'(carry_cnt), 32'hFF);

        // Backpressure: three beats offered, two fit
        out_ready = 1'b0;
        set_beat(1'b1, 16'h0101, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0); tick(ok);
        set_beat(1'b1, 16'h0202, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0); tick(ok);
        set_beat(1'b1, 16'h0303, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b0); tick(ok);
        check("bp_third_blocked", 32'(ok), 32'd0);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_head_held", 32'(out_sum), 32'h00102);
        tick(ok);
        out_ready = 1'b1;
        tick(ok);
        check("bp_pop_frees_next", 32'(ok), 32'd0);
        tick(ok);
        check("bp_third_accepted", 32'(ok), 32'd1);
        set_beat(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // clr with accept
        send(16'h00AA, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        send(16'h0000, 16'h0005, 1'b0, 1'b1, 1'b1, 1'b1);
        check("clr_out_sum", 32'(out_sum), 32'h00005);
        check("clr_out_last", 32'(out_last), 32'd1);
        check("clr_acc", 32'(acc), 32'h0005);
        check("clr_cnt", 32'(carry_cnt), 32'd0);
        drain();
        // clr without a beat
        send(16'hFFFF, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
        set_beat(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick(ok);
        clr = 1'b0;
        drain();
        check("clr_only_acc", 32'(acc), 32'd0);

        // Reset mid-stream with two entries queued
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b0);
        send(16'h3333, 16'h4444, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mid_full", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_acc", 32'(acc), 32'd0);
        check("mid_rst_cnt", 32'(carry_cnt), 32'd0);
        sbq.delete();
        m_acc = '0; m_cnt = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        tick(ok);
        tick(ok);

        // Random streaming
        beats   = 0;
        pending = 0;
        for (int cyc = 0; cyc < 60000 && beats < 10000; cyc++) begin
            if (!pending && $urandom_range(0, 3) != 0) begin
                set_beat(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                         1'($urandom), 1'b0);
                pending = 1;
            end
            clr       = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick(ok);
            if (ok) begin
                pending  = 0;
                in_valid = 1'b0;
                beats++;
            end
        end
        check("rand_beats", beats, 32'd10000);
        set_beat(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_cla16_sum_accumulator
